// File: rtl/thrower_pkg.sv
// ---------------------------------------------------------------------------
// thrower_pkg
// Shared definitions for the ball-thrower VGA game physics.
//   - screen / ground / target constants
//   - slot record (position, velocity, valid) used by the engine and stepper
//   - engine FSM state and step outcome enums
//   - near(): square-sprite coverage test used by the pixel overlay
// ---------------------------------------------------------------------------
package thrower_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int GROUND_Y = 450;
  localparam int TGT_LO   = 420;
  localparam int TGT_HI   = 540;

  // Positions carry one bit more than the scan counters so that off-screen
  // (negative or past the right edge) values stay representable.
  localparam int POS_W = 11;
  localparam int VEL_W = 10;

  typedef struct packed {
    logic signed [POS_W-1:0] x;
    logic signed [POS_W-1:0] y;
    logic signed [VEL_W-1:0] vx;
    logic signed [VEL_W-1:0] vy;
    logic                    valid;
  } slot_t;

  typedef enum logic {
    IDLE,
    SWEEP
  } eng_state_t;

  typedef enum logic [1:0] {
    OUT_NONE,
    OUT_HIT,
    OUT_MISS
  } outcome_t;

  // True when scan coordinate lies within +/-r of pos (one axis).
  function automatic logic near(input logic signed [POS_W-1:0] scan,
                                input logic signed [POS_W-1:0] pos,
                                input logic signed [POS_W:0]   r);
    logic signed [POS_W:0] d;
    d = {scan[POS_W-1], scan} - {pos[POS_W-1], pos};
    return (d >= -r) && (d <= r);
  endfunction

endpackage

// File: rtl/projectile_engine_if.sv
// ---------------------------------------------------------------------------
// projectile_engine_if
// Control / scan / status bundle between the game logic and the engine.
//   master (game side): update, launch, vel_x, vel_y, xCount, yCount
//   slave  (engine)   : ball_pix, hit, miss, score, active, overrun
// ---------------------------------------------------------------------------
interface projectile_engine_if #(
  parameter int N_BALLS = 4,
  parameter int XW      = 10,
  parameter int VW      = 10
);
  logic                 update;
  logic                 launch;
  logic signed [VW-1:0] vel_x;
  logic signed [VW-1:0] vel_y;
  logic [XW-1:0]        xCount;
  logic [XW-1:0]        yCount;
  logic                 ball_pix;
  logic                 hit;
  logic                 miss;
  logic [7:0]           score;
  logic [N_BALLS-1:0]   active;
  logic                 overrun;

  modport master (
    output update, launch, vel_x, vel_y, xCount, yCount,
    input  ball_pix, hit, miss, score, active, overrun
  );

  modport slave (
    input  update, launch, vel_x, vel_y, xCount, yCount,
    output ball_pix, hit, miss, score, active, overrun
  );
endinterface

// File: rtl/projectile_engine_step.sv
// ---------------------------------------------------------------------------
// projectile_step
// Purely combinational single-slot physics step, time-multiplexed across all
// slots by the engine sweep.
//   cur     : slot record before the step
//   nxt     : slot record after the step (valid cleared on hit/miss)
//   outcome : OUT_NONE / OUT_HIT / OUT_MISS
// ---------------------------------------------------------------------------
module projectile_step
  import thrower_pkg::*;
#(
  parameter int H_ACTIVE = thrower_pkg::H_ACTIVE,
  parameter int GROUND_Y = thrower_pkg::GROUND_Y,
  parameter int TGT_LO   = thrower_pkg::TGT_LO,
  parameter int TGT_HI   = thrower_pkg::TGT_HI,
  parameter int GRAVITY  = 1,
  parameter int BOUNCE   = 0
) (
  input  slot_t    cur,
  output slot_t    nxt,
  output outcome_t outcome
);

  localparam logic signed [POS_W-1:0] GND_P  = POS_W'(GROUND_Y);
  localparam logic signed [POS_W-1:0] HACT_P = POS_W'(H_ACTIVE);
  localparam logic signed [POS_W-1:0] TLO_P  = POS_W'(TGT_LO);
  localparam logic signed [POS_W-1:0] THI_P  = POS_W'(TGT_HI);
  localparam logic signed [VEL_W-1:0] GRAV_V = VEL_W'(GRAVITY);

  logic signed [POS_W-1:0] cx, cy, nx, ny;
  logic signed [VEL_W-1:0] cvx, cvy, nvy, rebound;

  always_comb begin
    cx  = cur.x;
    cy  = cur.y;
    cvx = cur.vx;
    cvy = cur.vy;

    // All three updates use the pre-step values; +vy means upward, so y shrinks.
    nx  = cx + POS_W'(cvx);
    ny  = cy - POS_W'(cvy);
    nvy = cvy - GRAV_V;

    // Bounce speed is derived from the vertical speed going into the contact.
    rebound = (-cvy) >> 1;

    nxt      = cur;
    nxt.x    = nx;
    nxt.y    = ny;
    nxt.vy   = nvy;
    outcome  = OUT_NONE;

    if (ny >= GND_P) begin
      nxt.y = GND_P;
      if ((nx > TLO_P) && (nx < THI_P)) begin
        outcome   = OUT_HIT;
        nxt.valid = 1'b0;
      end else if ((BOUNCE != 0) && (rebound != '0)) begin
        nxt.vy = rebound;
      end else begin
        outcome   = OUT_MISS;
        nxt.valid = 1'b0;
      end
    end else if (nx[POS_W-1] || (nx >= HACT_P)) begin
      // Leaving through the top of the screen is legal; only x is bounded.
      outcome   = OUT_MISS;
      nxt.valid = 1'b0;
    end
  end

endmodule

// File: rtl/projectile_engine.sv
// ---------------------------------------------------------------------------
// projectile_engine
// Multi-ball physics engine: up to N_BALLS projectiles, each stepped once per
// frame-update pulse by a sequential sweep through one shared stepper.
//   clk      : pixel clock (VGA_CLK domain)
//   rst      : asynchronous active-high reset
//   bus      : projectile_engine_if.slave
//              in : update, launch, vel_x, vel_y, xCount, yCount
//              out: ball_pix (registered), hit/miss (1-cycle pulses),
//                   score (saturating), active (slot mask), overrun (sticky)
// ---------------------------------------------------------------------------
module projectile_engine
  import thrower_pkg::*;
#(
  parameter int N_BALLS  = 4,
  parameter int XW       = 10,
  parameter int VW       = 10,
  parameter int H_ACTIVE = thrower_pkg::H_ACTIVE,
  parameter int GROUND_Y = thrower_pkg::GROUND_Y,
  parameter int TGT_LO   = thrower_pkg::TGT_LO,
  parameter int TGT_HI   = thrower_pkg::TGT_HI,
  parameter int START_X  = 20,
  parameter int START_Y  = 440,
  parameter int GRAVITY  = 1,
  parameter int BALL_R   = 4,
  parameter int BOUNCE   = 0
) (
  input logic                clk,
  input logic                rst,
  projectile_engine_if.slave bus
);

  localparam int IDX_W = (N_BALLS > 1) ? $clog2(N_BALLS) : 1;
  localparam logic signed [POS_W:0] RAD = (POS_W+1)'(BALL_R);

  function automatic logic [7:0] sat_inc(input logic [7:0] s);
    return (s == 8'hFF) ? s : s + 8'd1;
  endfunction

  slot_t                slots [N_BALLS];
  logic [N_BALLS-1:0]   active_vec;
  logic [N_BALLS-1:0]   sweep_mask, mask_nxt;
  eng_state_t           state, state_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [IDX_W-1:0]     free_idx;
  logic                 free_found;
  logic                 stepping;
  slot_t                launch_rec;
  slot_t                step_cur, step_nxt;
  outcome_t             step_out;
  logic signed [VW-1:0] lvx, lvy;
  logic [XW-1:0]        scan_x, scan_y;
  logic                 pix_any;

  logic                 ball_pix_p1;
  logic                 hit_p1;
  logic                 miss_p1;
  logic [7:0]           score_r;
  logic                 overrun_r;

  assign lvx    = bus.vel_x;
  assign lvy    = bus.vel_y;
  assign scan_x = bus.xCount;
  assign scan_y = bus.yCount;

  always_comb begin
    for (int i = 0; i < N_BALLS; i++) active_vec[i] = slots[i].valid;
  end

  // Lowest-index free slot; the downward loop lets the lowest index win.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = N_BALLS - 1; i >= 0; i--) begin
      if (!slots[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    launch_rec       = '0;
    launch_rec.x     = POS_W'(START_X);
    launch_rec.y     = POS_W'(START_Y);
    launch_rec.vx    = VEL_W'(lvx);
    launch_rec.vy    = VEL_W'(lvy);
    launch_rec.valid = 1'b1;
  end

  // Sweep FSM: one slot per cycle, only slots captured in the mask move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      sweep_mask <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      sweep_mask <= mask_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    mask_nxt  = sweep_mask;
    stepping  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.update) begin
          state_nxt = SWEEP;
          idx_nxt   = '0;
          mask_nxt  = active_vec;
        end
      end
      SWEEP: begin
        stepping = sweep_mask[idx];
        if (idx == IDX_W'(N_BALLS - 1)) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign step_cur = slots[idx];

  projectile_step #(
    .H_ACTIVE (H_ACTIVE),
    .GROUND_Y (GROUND_Y),
    .TGT_LO   (TGT_LO),
    .TGT_HI   (TGT_HI),
    .GRAVITY  (GRAVITY),
    .BOUNCE   (BOUNCE)
  ) u_step (
    .cur     (step_cur),
    .nxt     (step_nxt),
    .outcome (step_out)
  );

  // Step write-back and launch never target the same slot: a stepped slot is
  // valid, a launched one is free. A slot freed this cycle still reads valid,
  // so it is not reclaimed until the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_BALLS; i++) slots[i] <= '0;
    end else begin
      if (stepping) slots[idx] <= step_nxt;
      if (bus.launch && free_found) slots[free_idx] <= launch_rec;
    end
  end

  always_comb begin
    pix_any = 1'b0;
    for (int i = 0; i < N_BALLS; i++) begin
      if (slots[i].valid &&
          near(POS_W'({1'b0, scan_x}), slots[i].x, RAD) &&
          near(POS_W'({1'b0, scan_y}), slots[i].y, RAD))
        pix_any = 1'b1;
    end
  end

  // ---- stage p1: registered outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ball_pix_p1 <= 1'b0;
      hit_p1      <= 1'b0;
      miss_p1     <= 1'b0;
      score_r     <= 8'd0;
      overrun_r   <= 1'b0;
    end else begin
      ball_pix_p1 <= pix_any;
      hit_p1      <= stepping && (step_out == OUT_HIT);
      miss_p1     <= stepping && (step_out == OUT_MISS);
      if (stepping && (step_out == OUT_HIT)) score_r <= sat_inc(score_r);
      if ((state == SWEEP) && bus.update) overrun_r <= 1'b1;
    end
  end

  assign bus.ball_pix = ball_pix_p1;
  assign bus.hit      = hit_p1;
  assign bus.miss     = miss_p1;
  assign bus.score    = score_r;
  assign bus.active   = active_vec;
  assign bus.overrun  = overrun_r;

endmodule

// File: doc/projectile_engine.md
# projectile_engine

Multi-ball physics engine for the ball-thrower VGA game: replaces the single-ball mover with up to `N_BALLS` concurrent projectiles, each launched with a signed velocity pair from the angle/power lookup. The block steps every active ball once per frame-update pulse and classifies ground contacts as target hits or misses. It also keeps a saturating score and drives a registered per-pixel "ball here" bit into the colour mux next to the VGA controller.

## Interface
- `N_BALLS`, 4: number of projectile slots (1–8)
- `XW`, 10: pixel coordinate width
- `VW`, 10: signed velocity width
- `H_ACTIVE`, 640: visible width; x outside `[0, H_ACTIVE-1]` counts as a miss
- `GROUND_Y`, 450: ground line
- `TGT_LO` / `TGT_HI`, 420 / 540: target x range, exclusive bounds
- `START_X` / `START_Y`, 20 / 440: launch point
- `GRAVITY`, 1: subtracted from vy every step
- `BALL_R`, 4: half-size of the square ball sprite
- `BOUNCE`, 0: 0 = stop at ground; 1 = bounce with halved speed

Ports:
- `clk`, in, 1: pixel clock (VGA_CLK domain)
- `rst`, in, 1: asynchronous, active-high reset
- `update`, in, 1: one-cycle frame-step pulse
- `launch`, in, 1: one-cycle launch request
- `vel_x`, in, VW: signed launch vx (+ = right)
- `vel_y`, in, VW: signed launch vy (+ = up)
- `xCount`, in, XW: current scan x
- `yCount`, in, XW: current scan y
- `ball_pix`, out, 1: an active ball covers the current pixel
- `hit`, out, 1: one-cycle pulse on a target hit
- `miss`, out, 1: one-cycle pulse on a miss
- `score`, out, 8: saturating hit count
- `active`, out, N_BALLS: slot-occupied mask
- `overrun`, out, 1: sticky; set when `update` arrives during a sweep

## Operation
- Each slot holds `x`, `y` (signed, XW+1 bits), `vx`, `vy` (signed, VW bits) and a valid bit.
- **Launch:** claims the lowest-index free slot and loads `START_X`, `START_Y`, `vel_x`, `vel_y`. If all slots are valid, the launch is dropped silently.
- **FSM states:**
  - `IDLE`: on `update`, snapshot `active` into the sweep mask and go to `SWEEP`.
  - `SWEEP`: visit slot `i = 0..N_BALLS-1`, one per cycle. Step the slot only if its mask bit is set. After slot `N_BALLS-1`, return to `IDLE`.
- **Step arithmetic:** `x += vx`, `y -= vy`, `vy -= GRAVITY`. All updates use pre-step values. vy and the positions wrap at their widths; callers keep velocities bounded.
- **Ground contact** (new `y >= GROUND_Y`):
  - Clamp `y` to `GROUND_Y`.
  - If `TGT_LO < x < TGT_HI`: hit; free the slot; `score++`, saturating at 255.
  - Else if `BOUNCE=1` and `(-vy)>>1 != 0`: set `vy = (-vy)>>1` and keep flying.
  - Else: miss; free the slot.
- **Off-screen** (new `x < 0` or `x >= H_ACTIVE`): miss and free the slot. Ground contact is checked first. Negative y (above the screen) is legal.
- At most one slot is stepped per cycle, so `hit` and `miss` are never asserted together.
- **Pixel output:** `ball_pix` = OR over valid slots of `|xCount-x| <= BALL_R && |yCount-y| <= BALL_R`.
- **Same-cycle events:** a slot launched during a sweep is not in the mask and first moves on the next frame. A launch and a slot-free in the same cycle both take effect; the freed slot is not reused until the next cycle.
- **Reset:** asserting `rst` at any time, including mid-sweep, clears all slots, the FSM (to `IDLE`), `score`, `overrun`, and `ball_pix`, `hit`, `miss` to 0.

## Timing
- Launch: the slot becomes valid the cycle after `launch`.
- Sweep: starts the cycle after `update`; slot `i` is stepped in cycle `i+1`; the block is back in `IDLE` after `N_BALLS+1` cycles.
- `hit` / `miss` are registered and assert the cycle after the step that caused them.
- `ball_pix` is registered: 1-cycle latency from `xCount` / `yCount`. The top level delays ground/target by one cycle to match.
- An `update` arriving in `SWEEP` is ignored and sets `overrun`.

## Structure
- Shared package `thrower_pkg` holds:
  - screen constants `H_ACTIVE`, `V_ACTIVE`, `GROUND_Y`
  - target bounds
  - the slot record typedef (`x`, `y`, `vx`, `vy`, `valid`)
  - FSM state enum
  - hit/miss outcome enum
- Sub-module `projectile_step`: purely combinational single-slot step. Takes a slot record plus parameters; returns the next record and the outcome. Instantiated once and time-multiplexed by the sweep.

## Test plan
- Reset, then `launch` with vx=4, vy=10, then one `update` → slot0 holds x=24, y=430, vy=9; `active`=0001.
- Launch five times with `N_BALLS=4` → `active`=1111; the fifth launch is dropped and no state changes.
- Ball at x=480, y=448, vy=-3, then `update` → y clamped to 450; `hit` pulses once; `score` goes 0→1; slot freed.
- `BOUNCE=1`, ball at x=100 with a vy=-6 ground contact → vy=3, no `miss`. Repeat until vy=-1 → `miss`, slot freed.
- `update` pulses two cycles apart with `N_BALLS=4` → `overrun`=1; the second pulse is ignored. Then assert `rst` mid-sweep → all outputs 0, `active`=0000.
- Ball at x=100, y=200 with `xCount`=104, `yCount`=196 → `ball_pix`=1 one cycle later; with `xCount`=105 → 0.
